// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with iterative MULTU/DIVU behind start/ready/done.
// Optional divider datapath enabled by ALU_SEQ_DIVIDER_EN.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [3:0]         alu_operation_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               ready_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   alu_data_o,
    output logic [WIDTH-1:0]   hi_data_o,
    output logic               zero_o,
    output logic               overflow_o
);

    localparam logic [3:0] OP_SUB   = 4'b0000;
    localparam logic [3:0] OP_SRL   = 4'b0001;
    localparam logic [3:0] OP_LUI   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
`ifdef ALU_SEQ_DIVIDER_EN
    localparam logic [3:0] OP_DIVU  = 4'b1010;
`endif
    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = SHAMT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   wh_q, wh_d, wl_q, wl_d, opnd_q, opnd_d;
    logic [WIDTH-1:0]   alu_q, alu_d, hi_q, hi_d;
    logic               zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;
`ifdef ALU_SEQ_DIVIDER_EN
    logic               div_q, div_d;
    logic [WIDTH:0]     trial;
`endif

    logic [WIDTH-1:0]   sum, diff, short_res, nh, nl;
    logic [WIDTH:0]     mac;
    logic               short_ovf, is_long, accept;

    assign ready_o    = (state_q != S_BUSY);
    assign done_o     = done_q;
    assign alu_data_o = alu_q;
    assign hi_data_o  = hi_q;
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;
    assign accept     = start_i && ready_o;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    always_comb begin
        short_res = '0;
        short_ovf = 1'b0;
        case (alu_operation_i)
            OP_SUB: begin
                short_res = diff;
                short_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                            (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SRL: short_res = b_i >> shamt_i;
            OP_LUI: short_res = {b_i[HALF-1:0], {HALF{1'b0}}};
            OP_ADD: begin
                short_res = sum;
                short_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                            (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND: short_res = a_i & b_i;
            OP_SLL: short_res = b_i << shamt_i;
            OP_OR:  short_res = a_i | b_i;
            OP_NOR: short_res = ~(a_i | b_i);
            OP_SLT: short_res = {{(WIDTH-1){1'b0}},
                                 ($signed(a_i) < $signed(b_i))};
            default: short_res = '0;
        endcase
    end

`ifdef ALU_SEQ_DIVIDER_EN
    assign is_long = (alu_operation_i == OP_MULTU) ||
                     (alu_operation_i == OP_DIVU);
`else
    assign is_long = (alu_operation_i == OP_MULTU);
`endif

    // One iteration step: shift-add multiply or restoring divide
    always_comb begin
        mac = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        nh  = mac[WIDTH:1];
        nl  = {mac[0], wl_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIVIDER_EN
        trial = {wh_q, wl_q[WIDTH-1]};
        if (div_q) begin
            if (trial >= {1'b0, opnd_q}) begin
                nh = trial[WIDTH-1:0] - opnd_q;
                nl = {wl_q[WIDTH-2:0], 1'b1};
            end else begin
                nh = trial[WIDTH-1:0];
                nl = {wl_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wh_d    = wh_q;
        wl_d    = wl_q;
        opnd_d  = opnd_q;
        alu_d   = alu_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
`ifdef ALU_SEQ_DIVIDER_EN
        div_d   = div_q;
`endif
        case (state_q)
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                wh_d  = nh;
                wl_d  = nl;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    alu_d   = nl;
                    hi_d    = nh;
                    zero_d  = (nl == '0);
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (accept && is_long) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_W'(WIDTH);
                    wh_d    = '0;
                    wl_d    = b_i;
                    opnd_d  = a_i;
`ifdef ALU_SEQ_DIVIDER_EN
                    div_d   = (alu_operation_i == OP_DIVU);
                    if (div_d) begin
                        wl_d   = a_i;
                        opnd_d = b_i;
                    end
`endif
                end else if (accept) begin
                    alu_d  = short_res;
                    hi_d   = '0;
                    zero_d = (short_res == '0);
                    ovf_d  = short_ovf;
                    done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wh_q    <= '0;
            wl_q    <= '0;
            opnd_q  <= '0;
            alu_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SEQ_DIVIDER_EN
            div_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wh_q    <= wh_d;
            wl_q    <= wl_d;
            opnd_q  <= opnd_d;
            alu_q   <= alu_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
`ifdef ALU_SEQ_DIVIDER_EN
            div_q   <= div_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq at default WIDTH=32.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [3:0]  alu_operation_i;
    logic [31:0] a_i, b_i;
    logic [4:0]  shamt_i;
    logic        ready_o, done_o, zero_o, overflow_o;
    logic [31:0] alu_data_o, hi_data_o;

    int checks   = 0;
    int failures = 0;

    alu_seq dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .alu_operation_i (alu_operation_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .shamt_i         (shamt_i),
        .ready_o         (ready_o),
        .done_o          (done_o),
        .alu_data_o      (alu_data_o),
        .hi_data_o       (hi_data_o),
        .zero_o          (zero_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        start_i         = 1'b1;
        alu_operation_i = op;
        a_i             = a;
        b_i             = b;
        shamt_i         = sh;
    endtask

    task automatic short_op(input string tag, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh, input logic [31:0] exp,
                            input logic ez, input logic eo);
        drive(op, a, b, sh);
        tick();
        start_i = 1'b0;
        check({tag, "_done"}, {31'd0, done_o}, 32'd1);
        check({tag, "_res"}, alu_data_o, exp);
        check({tag, "_hi"}, hi_data_o, 32'd0);
        check({tag, "_zero"}, {31'd0, zero_o}, {31'd0, ez});
        check({tag, "_ovf"}, {31'd0, overflow_o}, {31'd0, eo});
    endtask

    // Issues a request, pokes start_i while busy, measures latency to done_o
    task automatic long_op(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [31:0] elo,
                           input logic [31:0] ehi, input logic ez);
        int n;
        int busy;
        drive(op, a, b, 5'd0);
        tick();
        start_i = 1'b0;
        n = 1;
        busy = 0;
        while (!done_o && n < 40) begin
            if (!ready_o) busy++;
            start_i = !ready_o && n[0];
            alu_operation_i = 4'b0011;
            tick();
            n++;
        end
        start_i = 1'b0;
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_busy"}, busy, exp_lat - 1);
        check({tag, "_rdy"}, {31'd0, ready_o}, 32'd1);
        check({tag, "_lo"}, alu_data_o, elo);
        check({tag, "_hi"}, hi_data_o, ehi);
        check({tag, "_zero"}, {31'd0, zero_o}, {31'd0, ez});
        check({tag, "_ovf"}, {31'd0, overflow_o}, 32'd0);
        tick();
        check({tag, "_pulse"}, {31'd0, done_o}, 32'd0);
        check({tag, "_hold"}, alu_data_o, elo);
    endtask

    initial begin
        int dn;
        reset = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 5'd0);
        start_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_alu", alu_data_o, 32'd0);
        check("rst_hi", hi_data_o, 32'd0);
        check("rst_zero", {31'd0, zero_o}, 32'd0);
        check("rst_ovf", {31'd0, overflow_o}, 32'd0);

        short_op("add_ovf", 4'b0011, 32'h7FFFFFFF, 32'd1, 5'd0,
                 32'h80000000, 1'b0, 1'b1);

        // Back-to-back short requests on consecutive edges
        drive(4'b0000, 32'd5, 32'd5, 5'd0);
        tick();
        check("b2b_sub_done", {31'd0, done_o}, 32'd1);
        check("b2b_sub", alu_data_o, 32'd0);
        check("b2b_sub_zero", {31'd0, zero_o}, 32'd1);
        drive(4'b0101, 32'd0, 32'd1, 5'd31);
        tick();
        check("b2b_sll_done", {31'd0, done_o}, 32'd1);
        check("b2b_sll", alu_data_o, 32'h80000000);
        drive(4'b0010, 32'd0, 32'h00001234, 5'd0);
        tick();
        start_i = 1'b0;
        check("b2b_lui_done", {31'd0, done_o}, 32'd1);
        check("b2b_lui", alu_data_o, 32'h12340000);
        check("b2b_lui_zero", {31'd0, zero_o}, 32'd0);
        tick();
        check("idle_done", {31'd0, done_o}, 32'd0);
        check("idle_hold", alu_data_o, 32'h12340000);

        short_op("sub_ovf", 4'b0000, 32'h80000000, 32'd1, 5'd0,
                 32'h7FFFFFFF, 1'b0, 1'b1);
        short_op("and", 4'b0100, 32'h0000F0F0, 32'h0000FF00, 5'd0,
                 32'h0000F000, 1'b0, 1'b0);
        short_op("or", 4'b0110, 32'h0000F0F0, 32'h0000FF00, 5'd0,
                 32'h0000FFF0, 1'b0, 1'b0);
        short_op("nor", 4'b0111, 32'd0, 32'd0, 5'd0,
                 32'hFFFFFFFF, 1'b0, 1'b0);
        short_op("srl", 4'b0001, 32'd0, 32'h80000000, 5'd4,
                 32'h08000000, 1'b0, 1'b0);
        short_op("slt_t", 4'b1000, 32'hFFFFFFFF, 32'd1, 5'd0,
                 32'd1, 1'b0, 1'b0);
        short_op("slt_f", 4'b1000, 32'd1, 32'hFFFFFFFF, 5'd0,
                 32'd0, 1'b1, 1'b0);

        long_op("multu", 4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33,
                32'h00000001, 32'hFFFFFFFE, 1'b0);
        short_op("op_bad", 4'b1111, 32'd3, 32'd4, 5'd0,
                 32'd0, 1'b1, 1'b0);
        long_op("multu2", 4'b1001, 32'd12345, 32'd1000, 33,
                32'd12345000, 32'd0, 1'b0);
`ifdef ALU_SEQ_DIVIDER_EN
        long_op("divu", 4'b1010, 32'd100, 32'd7, 33,
                32'd14, 32'd2, 1'b0);
        long_op("divu_z", 4'b1010, 32'h00001234, 32'd0, 33,
                32'hFFFFFFFF, 32'h00001234, 1'b0);
`else
        long_op("divu", 4'b1010, 32'd100, 32'd7, 1,
                32'd0, 32'd0, 1'b1);
        long_op("divu_z", 4'b1010, 32'h00001234, 32'd0, 1,
                32'd0, 32'd0, 1'b1);
`endif

        // Reset during BUSY cycle 10 of a multiply
        drive(4'b1001, 32'd9, 32'd9, 5'd0);
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mid_busy", {31'd0, ready_o}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_ready", {31'd0, ready_o}, 32'd1);
        check("mrst_done", {31'd0, done_o}, 32'd0);
        check("mrst_alu", alu_data_o, 32'd0);
        check("mrst_hi", hi_data_o, 32'd0);
        check("mrst_zero", {31'd0, zero_o}, 32'd0);
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done_o) dn++;
        end
        check("mrst_no_done", dn, 0);
        short_op("add_after", 4'b0011, 32'd2, 32'd3, 5'd0,
                 32'd5, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the single-cycle datapath ALU for the MIPS core. It executes the existing logic/arithmetic/shift/LUI set in one clocked cycle. It adds AND, NOR, SLT, and iterative unsigned multiply and divide producing HI/LO results. It sits in the EX stage behind a start/ready/done handshake, so the multi-cycle control path can stall on long operations.

## Interface
- `WIDTH`, default 32: datapath width in bits; must be even and at least 8.
- `SHAMT_W`, default 5: shift-amount width; must equal `$clog2(WIDTH)`.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high reset.
- `start_i`, input, 1: operation request; accepted only when `ready_o` is 1.
- `alu_operation_i`, input, 4: opcode, sampled at acceptance.
- `a_i`, input, WIDTH: operand A (RS), sampled at acceptance.
- `b_i`, input, WIDTH: operand B (RT), sampled at acceptance.
- `shamt_i`, input, SHAMT_W: shift amount, sampled at acceptance.
- `ready_o`, output, 1: block is idle and can accept a request.
- `done_o`, output, 1: one-cycle pulse; results are updated this cycle.
- `alu_data_o`, output, WIDTH: main result (LO for MULTU/DIVU).
- `hi_data_o`, output, WIDTH: HI result; 0 for every opcode except MULTU/DIVU.
- `zero_o`, output, 1: `alu_data_o == 0`.
- `overflow_o`, output, 1: signed overflow for ADD/SUB; 0 for all other opcodes.

## Operation
- Opcodes:
  - SUB=0000: a-b.
  - SRL=0001: b>>shamt.
  - LUI=0010: {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - ADD=0011: a+b.
  - AND=0100: a&b.
  - SLL=0101: b<<shamt.
  - OR=0110: a|b.
  - NOR=0111: ~(a|b).
  - SLT=1000: signed a<b → 1, else 0.
  - MULTU=1001: {HI,LO}=a*b, unsigned.
  - DIVU=1010: LO=a/b, HI=a%b, unsigned.
  - Any other opcode: alu_data_o=0, zero_o=1.
- Arithmetic is modulo 2^WIDTH.
- overflow_o is set when operands of equal sign give a sum of opposite sign (ADD). It is set when operands of differing sign give a difference whose sign differs from a (SUB).
- FSM states:
  - IDLE: ready_o=1. Short opcode accepted → result registered, stay in IDLE. MULTU/DIVU accepted → load operands and counter=WIDTH, go to BUSY.
  - BUSY: ready_o=0; one shift-add (MULTU) or restoring shift-subtract (DIVU) step per cycle; counter decrements. When counter reaches 0 → write HI/LO, go to DONE.
  - DONE: done_o=1 and ready_o=1. A request may be accepted in this cycle with the same rules as IDLE. Otherwise go to IDLE.
- Divide by zero: LO=all ones, HI=a, zero_o=0. The divide still takes the full latency.
- Outputs hold their last values until the next done_o; start_i while busy is ignored.
- Reset (at any time, including mid-BUSY) → IDLE, discard the operation. All outputs go to 0 except ready_o=1.

## Timing
- Acceptance: the rising edge at which start_i=1 and ready_o=1. Call it edge k.
- Short opcodes: results and done_o=1 are visible in the cycle after edge k, i.e. latency 1. Back-to-back short requests are sustainable every cycle.
- MULTU/DIVU: ready_o=0 for cycles k+1..k+WIDTH. done_o=1 with valid HI/LO at cycle k+WIDTH+1, i.e. latency WIDTH+1 (33 at default).
- zero_o and overflow_o change only together with done_o.
- ready_o is a combinational decode of state; done_o is registered.

## Configuration
- `ALU_SEQ_DIVIDER_EN`:
  - Defined: DIVU is implemented as specified above.
  - Undefined: the divider datapath is not compiled. DIVU is treated as an unsupported opcode: latency 1, alu_data_o=0, hi_data_o=0, zero_o=1. MULTU is unaffected.

## Test plan
- Reset, then ADD a=0x7FFFFFFF, b=1 → next cycle done_o=1, alu_data_o=0x80000000, overflow_o=1, zero_o=0.
- Back-to-back SUB 5-5, SLL b=1 shamt=31, LUI b=0x1234 on consecutive cycles → consecutive done_o pulses with results 0 (zero_o=1), 0x80000000, 0x12340000.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → ready_o low for 32 cycles, done_o at cycle 33, hi=0xFFFFFFFE, lo=0x00000001. start_i pulses while busy are ignored.
- DIVU a=100, b=7 → lo=14, hi=2 at latency 33. DIVU b=0 → lo=0xFFFFFFFF, hi=a. Without the macro, either DIVU → 0 after 1 cycle.
- Reset asserted at BUSY cycle 10 of MULTU → next cycle ready_o=1, all results 0, no done_o. A following ADD 2+3 returns 5.
- SLT a=0xFFFFFFFF, b=1 → alu_data_o=1. Opcode 1111 → alu_data_o=0, zero_o=1.
